ide_sector_loader: RTL and testbench



---
 rtl/ide_sector_loader.sv | 192 +++++++++++++++++++
 tb/tb_ide_sector_loader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ide_sector_loader.sv
// Streams bytes into the IDE data buffer (0x200-0x3FF), then programs iopos/iotarget/iocontrol and status.
// Optional `IDE_LOADER_CSUM_EN adds a csum[15:0] output: little-endian word sum of the loaded sector.
module ide_sector_loader #(
  parameter logic [7:0] STATUS_VAL = 8'h58,
  parameter logic [7:0] IOCTL_VAL  = 8'h02
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        start,
  input  logic [9:0]  len,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [9:0]  sram_a,
  output logic [7:0]  sram_d_out,
  output logic        sram_cs,
  output logic        sram_we,
  output logic        busy,
  output logic        done
`ifdef IDE_LOADER_CSUM_EN
  ,
  output logic [15:0] csum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_PAD, S_POS, S_TGT, S_CTL, S_STAT, S_FIN
  } state_t;

  state_t      r_state, w_nxt_state;
  logic [9:0]  r_n, w_nxt_n;
  logic [9:0]  r_cnt, w_nxt_cnt;
  logic        r_in_ready, w_nxt_in_ready;
  logic [9:0]  r_a, w_nxt_a;
  logic [7:0]  r_d, w_nxt_d;
  logic        r_wr, w_nxt_wr;
  logic        r_busy, w_nxt_busy;
  logic        r_done, w_nxt_done;

  logic        w_accept;
  logic [9:0]  w_len_n;
  logic [9:0]  w_cnt_inc;
  logic        w_last;
  logic [9:0]  w_m;
  logic [7:0]  w_tgt;

  assign w_accept  = in_valid & r_in_ready;
  assign w_len_n   = (len == 10'd0) ? 10'd512 : len;
  assign w_cnt_inc = r_cnt + 10'd1;
  assign w_last    = (w_cnt_inc == r_n);
  // Odd lengths are padded to a whole word; iotarget is the last word index.
  assign w_m       = r_n + {9'd0, r_n[0]};
  assign w_tgt     = 8'((w_m - 10'd2) >> 1);

`ifdef IDE_LOADER_CSUM_EN
  logic [15:0] r_csum, w_nxt_csum;
  logic [15:0] w_csum_add;
  assign w_csum_add = r_cnt[0] ? {in_data, 8'h00} : {8'h00, in_data};
  assign csum       = r_csum;
`endif

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_n        = r_n;
    w_nxt_cnt      = r_cnt;
    w_nxt_in_ready = r_in_ready;
    w_nxt_a        = r_a;
    w_nxt_d        = r_d;
    w_nxt_wr       = 1'b0;
    w_nxt_busy     = r_busy;
    w_nxt_done     = 1'b0;
`ifdef IDE_LOADER_CSUM_EN
    w_nxt_csum     = r_csum;
`endif
    if (r_state != S_IDLE && abort) begin
      w_nxt_state    = S_IDLE;
      w_nxt_in_ready = 1'b0;
      w_nxt_busy     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            w_nxt_state    = S_STREAM;
            w_nxt_n        = w_len_n;
            w_nxt_cnt      = 10'd0;
            w_nxt_in_ready = 1'b1;
            w_nxt_busy     = 1'b1;
`ifdef IDE_LOADER_CSUM_EN
            w_nxt_csum     = 16'h0000;
`endif
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            w_nxt_wr  = 1'b1;
            w_nxt_a   = 10'h200 + r_cnt;
            w_nxt_d   = in_data;
            w_nxt_cnt = w_cnt_inc;
`ifdef IDE_LOADER_CSUM_EN
            w_nxt_csum = r_csum + w_csum_add;
`endif
            if (w_last) begin
              w_nxt_in_ready = 1'b0;
              w_nxt_state    = r_n[0] ? S_PAD : S_POS;
            end
          end
        end
        S_PAD: begin
          w_nxt_wr    = 1'b1;
          w_nxt_a     = 10'h200 + r_n;
          w_nxt_d     = 8'h00;
          w_nxt_state = S_POS;
        end
        S_POS: begin
          w_nxt_wr    = 1'b1;
          w_nxt_a     = 10'h003;
          w_nxt_d     = 8'h00;
          w_nxt_state = S_TGT;
        end
        S_TGT: begin
          w_nxt_wr    = 1'b1;
          w_nxt_a     = 10'h005;
          w_nxt_d     = w_tgt;
          w_nxt_state = S_CTL;
        end
        S_CTL: begin
          w_nxt_wr    = 1'b1;
          w_nxt_a     = 10'h002;
          w_nxt_d     = IOCTL_VAL;
          w_nxt_state = S_STAT;
        end
        S_STAT: begin
          w_nxt_wr    = 1'b1;
          w_nxt_a     = 10'h000;
          w_nxt_d     = STATUS_VAL;
          w_nxt_state = S_FIN;
        end
        S_FIN: begin
          // Status strobe is on the port this cycle; done follows it.
          w_nxt_done  = 1'b1;
          w_nxt_busy  = 1'b0;
          w_nxt_state = S_IDLE;
        end
        default: begin
          w_nxt_state    = S_IDLE;
          w_nxt_in_ready = 1'b0;
          w_nxt_busy     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state    <= S_IDLE;
      r_n        <= 10'd0;
      r_cnt      <= 10'd0;
      r_in_ready <= 1'b0;
      r_a        <= 10'd0;
      r_d        <= 8'd0;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef IDE_LOADER_CSUM_EN
      r_csum     <= 16'h0000;
`endif
    end else begin
      r_state    <= w_nxt_state;
      r_n        <= w_nxt_n;
      r_cnt      <= w_nxt_cnt;
      r_in_ready <= w_nxt_in_ready;
      r_a        <= w_nxt_a;
      r_d        <= w_nxt_d;
      r_wr       <= w_nxt_wr;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
`ifdef IDE_LOADER_CSUM_EN
      r_csum     <= w_nxt_csum;
`endif
    end
  end

  assign in_ready   = r_in_ready;
  assign sram_a     = r_a;
  assign sram_d_out = r_d;
  assign sram_cs    = r_wr;
  assign sram_we    = r_wr;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_ide_sector_loader.sv
// Directed bench for ide_sector_loader: logs every SRAM write and checks it against hand-built tables.
module tb_ide_sector_loader;

  logic       clk = 1'b0;
  logic       reset_;
  logic       start;
  logic [9:0] len;
  logic       abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] sram_a;
  logic [7:0] sram_d_out;
  logic       sram_cs;
  logic       sram_we;
  logic       busy;
  logic       done;
`ifdef IDE_LOADER_CSUM_EN
  logic [15:0] csum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] la[$];
  logic [7:0] ld[$];
  int         done_cnt = 0;
  logic       done_busy = 1'b1;

  ide_sector_loader dut (
    .clk        (clk),
    .reset_     (reset_),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sram_a     (sram_a),
    .sram_d_out (sram_d_out),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .busy       (busy),
    .done       (done)
`ifdef IDE_LOADER_CSUM_EN
    ,
    .csum       (csum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sram_cs === 1'b1 && sram_we === 1'b1) begin
      la.push_back(sram_a);
      ld.push_back(sram_d_out);
    end
    if (done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_busy = busy;
    end
  end

  task automatic clear_log();
    la.delete();
    ld.delete();
    done_cnt  = 0;
    done_busy = 1'b1;
  endtask

  task automatic do_start(input logic [9:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte: byte %02h not accepted within 40 cycles", v);
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (done_cnt != 0) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL wait_done: done not seen within 200 cycles");
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0; start = 1'b0; abort = 1'b0; len = 10'd0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({in_ready, sram_cs, sram_we, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, sram_cs, sram_we, busy, done});
    end
    n_checks++; if (sram_a !== 10'h000) begin
      n_fail++; $display("FAIL reset_a: got %03h want 000", sram_a);
    end
    n_checks++; if (sram_d_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_d: got %02h want 00", sram_d_out);
    end
`ifdef IDE_LOADER_CSUM_EN
    n_checks++; if (csum !== 16'h0000) begin
      n_fail++; $display("FAIL reset_csum: got %04h want 0000", csum);
    end
`endif
    @(posedge clk); #1;
    reset_ = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_len4();
    logic [17:0] exp_w [8];
    logic [17:0] got;
    exp_w = '{{10'h200, 8'h11}, {10'h201, 8'h22}, {10'h202, 8'h33}, {10'h203, 8'h44},
              {10'h003, 8'h00}, {10'h005, 8'h01}, {10'h002, 8'h02}, {10'h000, 8'h58}};
    clear_log();
    do_start(10'd4);
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL len4_start: busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    n_checks++; if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL len4_rdy_drop: got %b want 0", in_ready);
    end
    wait_done();
    n_checks++; if (la.size() != 8) begin
      n_fail++; $display("FAIL len4_count: got %0d writes want 8", la.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < la.size()) ? {la[i], ld[i]} : 18'h3FFFF;
      n_checks++; if (got !== exp_w[i]) begin
        n_fail++; $display("FAIL len4_w%0d: got %03h:%02h want %03h:%02h", i, got[17:8], got[7:0], exp_w[i][17:8], exp_w[i][7:0]);
      end
    end
    n_checks++; if (done_cnt != 1 || done_busy !== 1'b0) begin
      n_fail++; $display("FAIL len4_done: pulses=%0d busy_at_done=%b want 1 0", done_cnt, done_busy);
    end
`ifdef IDE_LOADER_CSUM_EN
    n_checks++; if (csum !== 16'h6644) begin
      n_fail++; $display("FAIL len4_csum: got %04h want 6644", csum);
    end
`endif
  endtask

  task automatic test_len3_pad();
    logic [17:0] exp_w [8];
    logic [17:0] got;
    exp_w = '{{10'h200, 8'hAA}, {10'h201, 8'hBB}, {10'h202, 8'hCC}, {10'h203, 8'h00},
              {10'h003, 8'h00}, {10'h005, 8'h01}, {10'h002, 8'h02}, {10'h000, 8'h58}};
    clear_log();
    do_start(10'd3);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_done();
    n_checks++; if (la.size() != 8) begin
      n_fail++; $display("FAIL len3_count: got %0d writes want 8", la.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < la.size()) ? {la[i], ld[i]} : 18'h3FFFF;
      n_checks++; if (got !== exp_w[i]) begin
        n_fail++; $display("FAIL len3_w%0d: got %03h:%02h want %03h:%02h", i, got[17:8], got[7:0], exp_w[i][17:8], exp_w[i][7:0]);
      end
    end
    n_checks++; if (done_cnt != 1) begin
      n_fail++; $display("FAIL len3_done: pulses=%0d want 1", done_cnt);
    end
`ifdef IDE_LOADER_CSUM_EN
    n_checks++; if (csum !== 16'hBC76) begin
      n_fail++; $display("FAIL len3_csum: got %04h want BC76", csum);
    end
`endif
  endtask

  task automatic test_len512_toggle();
    int bad;
    logic [17:0] tail [4];
    logic [17:0] got;
    tail = '{{10'h003, 8'h00}, {10'h005, 8'hFF}, {10'h002, 8'h02}, {10'h000, 8'h58}};
    clear_log();
    do_start(10'd0);
    for (int i = 0; i < 512; i++) begin
      send_byte(8'(i * 7 + 3));
      if (i != 511) begin
        @(posedge clk); #1;
      end
    end
    n_checks++; if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL len512_rdy_drop: got %b want 0", in_ready);
    end
    in_valid = 1'b1; in_data = 8'hEE;
    wait_done();
    in_valid = 1'b0;
    n_checks++; if (la.size() != 516) begin
      n_fail++; $display("FAIL len512_count: got %0d writes want 516", la.size());
    end
    bad = 0;
    for (int i = 0; i < 512 && i < la.size(); i++)
      if (la[i] !== 10'(10'h200 + i) || ld[i] !== 8'(i * 7 + 3)) bad++;
    n_checks++; if (bad != 0) begin
      n_fail++; $display("FAIL len512_buffer: got %0d bad buffer writes want 0", bad);
    end
    for (int i = 0; i < 4; i++) begin
      got = (512 + i < la.size()) ? {la[512 + i], ld[512 + i]} : 18'h3FFFF;
      n_checks++; if (got !== tail[i]) begin
        n_fail++; $display("FAIL len512_reg%0d: got %03h:%02h want %03h:%02h", i, got[17:8], got[7:0], tail[i][17:8], tail[i][7:0]);
      end
    end
  endtask

  task automatic test_abort();
    bit hit_reg;
    clear_log();
    do_start(10'd20);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    repeat (20) @(posedge clk); #1;
    n_checks++; if (la.size() != 10) begin
      n_fail++; $display("FAIL abort_count: got %0d writes want 10", la.size());
    end
    hit_reg = 1'b0;
    foreach (la[i]) if (la[i] < 10'h200) hit_reg = 1'b1;
    n_checks++; if (hit_reg || done_cnt != 0) begin
      n_fail++; $display("FAIL abort_regs: reg_write=%b done_pulses=%0d want 0 0", hit_reg, done_cnt);
    end
  endtask

  task automatic test_start_abort_idle();
    clear_log();
    start = 1'b1; abort = 1'b1; len = 10'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL start_abort: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    repeat (5) @(posedge clk); #1;
    n_checks++; if (la.size() != 0) begin
      n_fail++; $display("FAIL start_abort_writes: got %0d writes want 0", la.size());
    end
  endtask

  task automatic test_reset_mid_load();
    logic [17:0] exp_w [3];
    logic [17:0] got;
    exp_w = '{{10'h200, 8'h01}, {10'h201, 8'h02}, {10'h003, 8'h00}};
    clear_log();
    do_start(10'd2);
    send_byte(8'h01); send_byte(8'h02);
    @(posedge clk); #1;
    reset_ = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({in_ready, sram_cs, sram_we, busy, done, sram_a, sram_d_out} !== 23'd0) begin
      n_fail++; $display("FAIL midreset_outs: got rdy=%b cs=%b we=%b busy=%b done=%b a=%03h d=%02h want all 0",
                         in_ready, sram_cs, sram_we, busy, done, sram_a, sram_d_out);
    end
    @(posedge clk); #1;
    reset_ = 1'b1;
    repeat (15) @(posedge clk); #1;
    n_checks++; if (la.size() != 3 || done_cnt != 0) begin
      n_fail++; $display("FAIL midreset_count: got %0d writes %0d done want 3 0", la.size(), done_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < la.size()) ? {la[i], ld[i]} : 18'h3FFFF;
      n_checks++; if (got !== exp_w[i]) begin
        n_fail++; $display("FAIL midreset_w%0d: got %03h:%02h want %03h:%02h", i, got[17:8], got[7:0], exp_w[i][17:8], exp_w[i][7:0]);
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [17:0] exp_w [8];
    logic [17:0] got;
    exp_w = '{{10'h200, 8'h5A}, {10'h201, 8'hA5}, {10'h202, 8'h3C}, {10'h203, 8'hC3},
              {10'h003, 8'h00}, {10'h005, 8'h01}, {10'h002, 8'h02}, {10'h000, 8'h58}};
    clear_log();
    do_start(10'd4);
    send_byte(8'h5A); send_byte(8'hA5);
    do_start(10'd8);
    send_byte(8'h3C); send_byte(8'hC3);
    n_checks++; if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL restart_rdy: got %b want 0", in_ready);
    end
    wait_done();
    n_checks++; if (la.size() != 8 || done_cnt != 1) begin
      n_fail++; $display("FAIL restart_count: got %0d writes %0d done want 8 1", la.size(), done_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < la.size()) ? {la[i], ld[i]} : 18'h3FFFF;
      n_checks++; if (got !== exp_w[i]) begin
        n_fail++; $display("FAIL restart_w%0d: got %03h:%02h want %03h:%02h", i, got[17:8], got[7:0], exp_w[i][17:8], exp_w[i][7:0]);
      end
    end
`ifdef IDE_LOADER_CSUM_EN
    n_checks++; if (csum !== 16'h6896) begin
      n_fail++; $display("FAIL restart_csum: got %04h want 6896", csum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_len4();
    test_len3_pad();
    test_len512_toggle();
    test_abort();
    test_start_abort_idle();
    test_reset_mid_load();
    test_restart_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
